goomba_controller: RTL and testbench

Per-frame motion and life-cycle controller for the Goomba sprite. Sits directly upstream of the background/sprite renderer: it drives the renderer's `GoombaX`, `GoombaY`, `GoombaXS`, `GoombaYS` and `reverse_g` inputs. It patrols the Goomba between two screen bounds, detects overlap with Mario, and runs a squash → gone → respawn sequence when Mario stomps it.

---
 rtl/goomba_controller.sv | 142 ++++++++++++++
 tb/tb_goomba_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/goomba_controller.sv
// Goomba sprite controller: patrols between screen bounds, detects contact with Mario,
// and runs a squash -> gone -> respawn sequence after a stomp.
module goomba_controller #(
  parameter int unsigned X_START        = 400,
  parameter int unsigned Y_GROUND       = 432,
  parameter int unsigned X_MIN          = 16,
  parameter int unsigned X_MAX          = 623,
  parameter int unsigned STEP           = 1,
  parameter int unsigned HALF           = 16,
  parameter int unsigned SQUASH_FRAMES  = 30,
  parameter int unsigned RESPAWN_FRAMES = 120
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] MarioX,
  input  logic [9:0] MarioY,
  input  logic [9:0] MarioXS,
  input  logic [9:0] MarioYS,
  input  logic       mario_falling,
  output logic [9:0] GoombaX,
  output logic [9:0] GoombaY,
  output logic [9:0] GoombaXS,
  output logic [9:0] GoombaYS,
  output logic       reverse_g,
  output logic       goomba_alive,
  output logic       stomp,
  output logic       hit_mario
);

  localparam logic [9:0] XStart   = 10'(X_START);
  localparam logic [9:0] YGround  = 10'(Y_GROUND);
  localparam logic [9:0] XMin     = 10'(X_MIN);
  localparam logic [9:0] XMax     = 10'(X_MAX);
  localparam logic [9:0] Step     = 10'(STEP);
  localparam logic [9:0] Half     = 10'(HALF);
  localparam logic [9:0] HalfSq   = 10'(HALF / 2);
  // Squashed sprite keeps its bottom edge on the ground.
  localparam logic [9:0] YSquash  = 10'(Y_GROUND + HALF / 2);
  localparam logic [9:0] XLeftLim = 10'(X_MIN + STEP);
  localparam logic [9:0] XRightLim = 10'(X_MAX - STEP);
  localparam logic [6:0] SquashLast  = 7'(SQUASH_FRAMES - 1);
  localparam logic [6:0] RespawnLast = 7'(RESPAWN_FRAMES - 1);

  typedef enum logic [1:0] {StWalk, StSquash, StGone} state_e;

  state_e     state;
  logic [6:0] fcnt;

  logic [9:0] m_right, m_left, m_bottom, m_top;
  logic [9:0] g_right, g_left, g_bottom, g_top;
  logic       overlap;
  logic       stomped;

  // 10-bit unsigned edge compares; wrap-around is intentional.
  always_comb begin
    m_right  = MarioX + MarioXS;
    m_left   = MarioX - MarioXS;
    m_bottom = MarioY + MarioYS;
    m_top    = MarioY - MarioYS;
    g_right  = GoombaX + GoombaXS;
    g_left   = GoombaX - GoombaXS;
    g_bottom = GoombaY + GoombaYS;
    g_top    = GoombaY - GoombaYS;
    overlap  = (m_right >= g_left) && (m_left <= g_right) &&
               (m_bottom >= g_top) && (m_top <= g_bottom);
    stomped  = overlap && mario_falling && (MarioY < GoombaY);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state        <= StWalk;
      fcnt         <= '0;
      GoombaX      <= XStart;
      GoombaY      <= YGround;
      GoombaXS     <= Half;
      GoombaYS     <= Half;
      reverse_g    <= 1'b1;
      goomba_alive <= 1'b1;
      stomp        <= 1'b0;
      hit_mario    <= 1'b0;
    end else begin
      stomp     <= 1'b0;
      hit_mario <= 1'b0;
      if (frame_tick) begin
        unique case (state)
          StWalk: begin
            if (stomped) begin
              stomp    <= 1'b1;
              state    <= StSquash;
              fcnt     <= '0;
              GoombaYS <= HalfSq;
              GoombaY  <= YSquash;
            end else begin
              hit_mario <= overlap;
              if (reverse_g) begin
                if (GoombaX <= XLeftLim) begin
                  GoombaX   <= XMin;
                  reverse_g <= 1'b0;
                end else begin
                  GoombaX <= GoombaX - Step;
                end
              end else begin
                if (GoombaX >= XRightLim) begin
                  GoombaX   <= XMax;
                  reverse_g <= 1'b1;
                end else begin
                  GoombaX <= GoombaX + Step;
                end
              end
            end
          end
          StSquash: begin
            if (fcnt == SquashLast) begin
              state        <= StGone;
              fcnt         <= '0;
              goomba_alive <= 1'b0;
            end else begin
              fcnt <= fcnt + 7'd1;
            end
          end
          StGone: begin
            if (fcnt == RespawnLast) begin
              state        <= StWalk;
              fcnt         <= '0;
              GoombaX      <= XStart;
              GoombaY      <= YGround;
              GoombaXS     <= Half;
              GoombaYS     <= Half;
              reverse_g    <= 1'b1;
              goomba_alive <= 1'b1;
            end else begin
              fcnt <= fcnt + 7'd1;
            end
          end
          default: state <= StWalk;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_goomba_controller.sv
// Bench for goomba_controller: a frame-level behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_goomba_controller;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [9:0] MarioX, MarioY, MarioXS, MarioYS;
  logic       mario_falling;
  logic [9:0] GoombaX, GoombaY, GoombaXS, GoombaYS;
  logic       reverse_g, goomba_alive, stomp, hit_mario;

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  goomba_controller dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .MarioX       (MarioX),
    .MarioY       (MarioY),
    .MarioXS      (MarioXS),
    .MarioYS      (MarioYS),
    .mario_falling(mario_falling),
    .GoombaX      (GoombaX),
    .GoombaY      (GoombaY),
    .GoombaXS     (GoombaXS),
    .GoombaYS     (GoombaYS),
    .reverse_g    (reverse_g),
    .goomba_alive (goomba_alive),
    .stomp        (stomp),
    .hit_mario    (hit_mario)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: mode 0 walking, 1 squashed, 2 gone; frames counts elapsed frames.
  int m_x, m_y, m_xs, m_ys, m_rev, m_alive, m_stomp, m_hit, m_mode, m_frames;

  task automatic model_reset();
    m_x = 400; m_y = 432; m_xs = 16; m_ys = 16; m_rev = 1; m_alive = 1;
    m_stomp = 0; m_hit = 0; m_mode = 0; m_frames = 0;
  endtask

  task automatic model_frame();
    bit ov;
    int mx, my, mxs, mys;
    mx = MarioX; my = MarioY; mxs = MarioXS; mys = MarioYS;
    m_stomp = 0;
    m_hit   = 0;
    if (m_mode == 0) begin
      ov = ((mx + mxs) % 1024 >= m_x - m_xs) && ((mx - mxs + 1024) % 1024 <= m_x + m_xs) &&
           ((my + mys) % 1024 >= m_y - m_ys) && ((my - mys + 1024) % 1024 <= m_y + m_ys);
      if (ov && mario_falling && my < m_y) begin
        m_stomp = 1; m_mode = 1; m_frames = 0; m_ys = 8; m_y = 440;
      end else begin
        m_hit = ov;
        if (m_rev == 1) begin
          if (m_x - 1 <= 16) begin m_x = 16; m_rev = 0; end
          else m_x = m_x - 1;
        end else begin
          if (m_x + 1 >= 623) begin m_x = 623; m_rev = 1; end
          else m_x = m_x + 1;
        end
      end
    end else if (m_mode == 1) begin
      m_frames++;
      if (m_frames == 30) begin m_mode = 2; m_frames = 0; m_alive = 0; end
    end else begin
      m_frames++;
      if (m_frames == 120) model_reset();
    end
  endtask

  always @(posedge vga_clk) begin
    if (reset) model_reset();
    else if (frame_tick) model_frame();
    else begin m_stomp = 0; m_hit = 0; end
    #1;
    chk("m.GoombaX", GoombaX, m_x);
    chk("m.GoombaY", GoombaY, m_y);
    chk("m.GoombaXS", GoombaXS, m_xs);
    chk("m.GoombaYS", GoombaYS, m_ys);
    chk("m.reverse_g", reverse_g, m_rev);
    chk("m.goomba_alive", goomba_alive, m_alive);
    chk("m.stomp", stomp, m_stomp);
    chk("m.hit_mario", hit_mario, m_hit);
  end

  task automatic ticks(input int n);
    @(negedge vga_clk) frame_tick = 1'b1;
    repeat (n) @(negedge vga_clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge vga_clk) reset = 1'b1;
    @(negedge vga_clk) reset = 1'b0;
  endtask

  task automatic mario(input int x, input int y, input bit falling);
    MarioX = 10'(x); MarioY = 10'(y); mario_falling = falling;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0;
    MarioXS = 10'd16; MarioYS = 10'd16;
    mario(100, 100, 1'b0);
    repeat (2) @(negedge vga_clk);
    chk("rst.X", GoombaX, 400);
    chk("rst.rev", reverse_g, 1);
    reset = 1'b0;

    ticks(10);
    chk("walk10.X", GoombaX, 390);
    chk("walk10.rev", reverse_g, 1);

    ticks(372);
    chk("left.X18", GoombaX, 18);
    ticks(1); chk("left.X17", GoombaX, 17);
    ticks(1); chk("left.X16", GoombaX, 16); chk("left.rev0", reverse_g, 0);
    ticks(1); chk("left.X17b", GoombaX, 17);

    ticks(604);
    chk("right.X621", GoombaX, 621);
    ticks(1); chk("right.X622", GoombaX, 622);
    ticks(1); chk("right.X623", GoombaX, 623); chk("right.rev1", reverse_g, 1);
    ticks(1); chk("right.X622b", GoombaX, 622);

    do_reset();
    mario(380, 432, 1'b0);
    ticks(1);
    chk("side.hit", hit_mario, 1);
    chk("side.stomp", stomp, 0);
    chk("side.X", GoombaX, 399);

    do_reset();
    mario(400, 410, 1'b1);
    ticks(1);
    chk("stomp.pulse", stomp, 1);
    chk("stomp.hit", hit_mario, 0);
    chk("stomp.YS", GoombaYS, 8);
    chk("stomp.Y", GoombaY, 440);
    chk("stomp.X", GoombaX, 400);

    mario(100, 100, 1'b0);
    ticks(29); chk("life.alive29", goomba_alive, 1);
    ticks(1);  chk("life.alive30", goomba_alive, 0);
    ticks(119); chk("life.gone119", goomba_alive, 0);
    ticks(1);
    chk("respawn.alive", goomba_alive, 1);
    chk("respawn.X", GoombaX, 400);
    chk("respawn.Y", GoombaY, 432);
    chk("respawn.YS", GoombaYS, 16);
    chk("respawn.rev", reverse_g, 1);

    // Stomp again, reach GONE, then reset coinciding with a tick.
    mario(400, 410, 1'b1);
    ticks(1);
    mario(100, 100, 1'b0);
    ticks(35);
    chk("midgone.alive", goomba_alive, 0);
    @(negedge vga_clk) begin reset = 1'b1; frame_tick = 1'b1; end
    @(negedge vga_clk) begin reset = 1'b0; frame_tick = 1'b0; end
    chk("rstgone.alive", goomba_alive, 1);
    chk("rstgone.X", GoombaX, 400);
    chk("rstgone.Y", GoombaY, 432);
    chk("rstgone.YS", GoombaYS, 16);
    chk("rstgone.stomp", stomp, 0);
    ticks(1);
    chk("rstgone.walk", GoombaX, 399);

    repeat (2) @(negedge vga_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
